// File: rtl/rv_fetch_pkg.sv
// Shared definitions for the RVC fetch path.
//   RVC_OPC_FULL : low two opcode bits that mark a 32-bit instruction
//   hw_t         : one 16-bit instruction parcel
//   is_rvc()     : true when a parcel starts a compressed instruction
//   NOP_INS      : canonical addi x0,x0,0, kept for future bubble insertion
package rv_fetch_pkg;

  localparam logic [1:0]  RVC_OPC_FULL = 2'b11;
  localparam logic [31:0] NOP_INS      = 32'h0000_0013;

  typedef logic [15:0] hw_t;

  function automatic logic is_rvc(hw_t hw);
    return hw[1:0] != RVC_OPC_FULL;
  endfunction

endpackage

// File: rtl/rvc_hw_queue.sv
// Circular halfword FIFO feeding the instruction aligner.
//   clk_i, rst_i       : clock, asynchronous active-high reset
//   clear_i            : drop all contents (wins over push/pop)
//   push_n_i           : number of halfwords to push (0..2), push_hw0_i goes in first
//   pop_n_i            : number of halfwords to pop (0..2) from the head
//   head0_o, head1_o   : oldest and second-oldest entries
//   count_o            : current fill level
module rvc_hw_queue
  import rv_fetch_pkg::*;
#(
  parameter int unsigned Depth = 6,
  localparam int unsigned IdxW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clear_i,
  input  logic [1:0]      push_n_i,
  input  hw_t             push_hw0_i,
  input  hw_t             push_hw1_i,
  input  logic [1:0]      pop_n_i,
  output hw_t             head0_o,
  output hw_t             head1_o,
  output logic [CntW-1:0] count_o
);

  localparam logic [IdxW:0] DepthW = Depth[IdxW:0];

  hw_t             mem_q [Depth];
  logic [IdxW-1:0] wr_ptr_q, wr_ptr_d;
  logic [IdxW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  // Pointer advance modulo Depth (Depth need not be a power of two).
  function automatic logic [IdxW-1:0] ptr_add(logic [IdxW-1:0] ptr, logic [1:0] n);
    logic [IdxW:0] sum;
    sum = {1'b0, ptr} + {{(IdxW - 1){1'b0}}, n};
    if (sum >= DepthW) sum = sum - DepthW;
    return sum[IdxW-1:0];
  endfunction

  always_comb begin
    wr_ptr_d = ptr_add(wr_ptr_q, push_n_i);
    rd_ptr_d = ptr_add(rd_ptr_q, pop_n_i);
    count_d  = count_q + CntW'(push_n_i) - CntW'(pop_n_i);
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; count_q alone defines which entries are live.
  always_ff @(posedge clk_i) begin
    if (!clear_i && push_n_i != 2'd0) mem_q[wr_ptr_q] <= push_hw0_i;
    if (!clear_i && push_n_i == 2'd2) mem_q[ptr_add(wr_ptr_q, 2'd1)] <= push_hw1_i;
  end

  assign head0_o = mem_q[rd_ptr_q];
  assign head1_o = mem_q[ptr_add(rd_ptr_q, 2'd1)];
  assign count_o = count_q;

  no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !clear_i |-> ({1'b0, count_q} + (CntW + 1)'(push_n_i)
                  <= (CntW + 1)'(Depth) + (CntW + 1)'(pop_n_i)));

  no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !clear_i |-> (CntW'(pop_n_i) <= count_q));

endmodule

// File: rtl/rvc_fetch_aligner.sv
// Fetch aligner between instruction memory and Decode.
// Fetches 32-bit words, splits them into halfwords and presents one aligned
// (possibly compressed) instruction per cycle.
//   clk, Rst                 : clock, asynchronous active-high reset
//   fetch_req/addr/gnt       : word request channel to memory
//   rsp_valid/addr/data      : in-order response channel; mismatched addresses are dropped
//   redirect, redirect_addr  : flush and restart at a new PC
//   stall                    : Decode cannot accept this cycle
//   ins_valid, ins, comp_sig, pres_addr : instruction presented to Decode
module rvc_fetch_aligner
  import rv_fetch_pkg::*;
#(
  parameter int unsigned       DEPTH_HW   = 6,
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              Rst,
  output logic              fetch_req,
  output logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_gnt,
  input  logic              rsp_valid,
  input  logic [ADDR_W-1:0] rsp_addr,
  input  logic [31:0]       rsp_data,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              stall,
  output logic              ins_valid,
  output logic [31:0]       ins,
  output logic              comp_sig,
  output logic [ADDR_W-1:0] pres_addr
);

  localparam int unsigned CntW = $clog2(DEPTH_HW + 1);
  localparam int unsigned OutW = $clog2(DEPTH_HW / 2 + 1);
  localparam logic [ADDR_W-1:0] HwMask   = ~ADDR_W'(1);
  localparam logic [ADDR_W-1:0] WordMask = ~ADDR_W'(3);

  logic [ADDR_W-1:0] pres_addr_q, pres_addr_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [ADDR_W-1:0] exp_addr_q, exp_addr_d;
  logic              drop_low_q, drop_low_d;
  logic [OutW-1:0]   outstanding_q, outstanding_d;

  hw_t             head0, head1;
  logic [CntW-1:0] hw_count;
  logic            need_two, have_ins, rsp_accept, fetch_fire;
  logic [1:0]      push_n, pop_n;
  hw_t             push_hw0;
  logic [31:0]     free_slots, reserved;

  rvc_hw_queue #(
    .Depth (DEPTH_HW)
  ) u_queue (
    .clk_i      (clk),
    .rst_i      (Rst),
    .clear_i    (redirect),
    .push_n_i   (push_n),
    .push_hw0_i (push_hw0),
    .push_hw1_i (rsp_data[31:16]),
    .pop_n_i    (pop_n),
    .head0_o    (head0),
    .head1_o    (head1),
    .count_o    (hw_count)
  );

  // Each outstanding request may still deliver two halfwords; keep room for them.
  assign free_slots = DEPTH_HW - 32'(hw_count);
  assign reserved   = 32'(outstanding_q) * 32'd2 + 32'd2;
  assign fetch_req  = !redirect && (free_slots >= reserved);
  assign fetch_fire = fetch_req && fetch_gnt;

  assign rsp_accept = rsp_valid && (rsp_addr == exp_addr_q) && !redirect;
  assign push_n     = !rsp_accept ? 2'd0 : (drop_low_q ? 2'd1 : 2'd2);
  // After a redirect into the upper half of a word the low parcel is skipped.
  assign push_hw0   = drop_low_q ? rsp_data[31:16] : rsp_data[15:0];

  assign need_two  = !is_rvc(head0);
  assign have_ins  = need_two ? (hw_count >= CntW'(2)) : (hw_count >= CntW'(1));
  assign ins_valid = have_ins && !redirect;
  assign comp_sig  = ins_valid && !need_two;
  assign ins       = !ins_valid ? 32'h0 : (need_two ? {head1, head0} : {16'h0, head0});
  assign pop_n     = (ins_valid && !stall) ? (need_two ? 2'd2 : 2'd1) : 2'd0;

  always_comb begin
    pres_addr_d   = pres_addr_q;
    fetch_addr_d  = fetch_addr_q;
    exp_addr_d    = exp_addr_q;
    drop_low_d    = drop_low_q;
    outstanding_d = outstanding_q;
    if (redirect) begin
      pres_addr_d   = redirect_addr & HwMask;
      fetch_addr_d  = redirect_addr & WordMask;
      exp_addr_d    = redirect_addr & WordMask;
      drop_low_d    = redirect_addr[1];
      outstanding_d = '0;
    end else begin
      if (pop_n != 2'd0) pres_addr_d = pres_addr_q + (need_two ? ADDR_W'(4) : ADDR_W'(2));
      if (fetch_fire) fetch_addr_d = fetch_addr_q + ADDR_W'(4);
      if (rsp_accept) begin
        exp_addr_d = exp_addr_q + ADDR_W'(4);
        drop_low_d = 1'b0;
      end
      outstanding_d = outstanding_q + OutW'(fetch_fire) - OutW'(rsp_accept);
    end
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      pres_addr_q   <= RESET_ADDR;
      fetch_addr_q  <= RESET_ADDR & WordMask;
      exp_addr_q    <= RESET_ADDR & WordMask;
      drop_low_q    <= RESET_ADDR[1];
      outstanding_q <= '0;
    end else begin
      pres_addr_q   <= pres_addr_d;
      fetch_addr_q  <= fetch_addr_d;
      exp_addr_q    <= exp_addr_d;
      drop_low_q    <= drop_low_d;
      outstanding_q <= outstanding_d;
    end
  end

  assign fetch_addr = fetch_addr_q;
  assign pres_addr  = pres_addr_q;

endmodule

// File: tb/tb_rvc_fetch_aligner.sv
// Bench for rvc_fetch_aligner: directed scenarios followed by a randomized run
// against a memory-image model that walks the program by PC.
module tb_rvc_fetch_aligner;

  logic        clk = 1'b0;
  logic        Rst;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_gnt;
  logic        rsp_valid;
  logic [31:0] rsp_addr;
  logic [31:0] rsp_data;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        stall;
  logic        ins_valid;
  logic [31:0] ins;
  logic        comp_sig;
  logic [31:0] pres_addr;

  rvc_fetch_aligner #(
    .DEPTH_HW   (6),
    .ADDR_W     (32),
    .RESET_ADDR (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .Rst           (Rst),
    .fetch_req     (fetch_req),
    .fetch_addr    (fetch_addr),
    .fetch_gnt     (fetch_gnt),
    .rsp_valid     (rsp_valid),
    .rsp_addr      (rsp_addr),
    .rsp_data      (rsp_data),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .stall         (stall),
    .ins_valid     (ins_valid),
    .ins           (ins),
    .comp_sig      (comp_sig),
    .pres_addr     (pres_addr)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after the edge, outputs are sampled 2 ns after it.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    #1;
  endtask

  task automatic chk_ins(input string tag, input logic [31:0] e_ins, input logic [31:0] e_pc,
                         input logic e_comp);
    check_eq({tag, "_valid"}, {31'b0, ins_valid}, 32'd1);
    check_eq({tag, "_ins"}, ins, e_ins);
    check_eq({tag, "_pc"}, pres_addr, e_pc);
    check_eq({tag, "_comp"}, {31'b0, comp_sig}, {31'b0, e_comp});
  endtask

  task automatic chk_reset_vals(input string tag);
    check_eq({tag, "_valid"}, {31'b0, ins_valid}, 32'd0);
    check_eq({tag, "_ins"}, ins, 32'd0);
    check_eq({tag, "_comp"}, {31'b0, comp_sig}, 32'd0);
    check_eq({tag, "_pc"}, pres_addr, 32'd0);
    check_eq({tag, "_faddr"}, fetch_addr, 32'd0);
    check_eq({tag, "_freq"}, {31'b0, fetch_req}, 32'd1);
  endtask

  task automatic send_rsp(input logic [31:0] a, input logic [31:0] d);
    rsp_valid = 1'b1;
    rsp_addr  = a;
    rsp_data  = d;
  endtask

  task automatic grant_n(input int n);
    fetch_gnt = 1'b1;
    repeat (n) nxt();
    fetch_gnt = 1'b0;
  endtask

  task automatic do_redirect(input logic [31:0] a);
    redirect      = 1'b1;
    redirect_addr = a;
    nxt();
    redirect = 1'b0;
  endtask

  // Program image: deterministic per word address, mixing 16/32-bit parcels.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = (a ^ 32'h5bd1_e995) * 32'h2545_f491;
    return w ^ (w >> 15);
  endfunction

  function automatic logic [15:0] mem_hw(input logic [31:0] a);
    logic [31:0] w;
    w = mem_word(a & ~32'd3);
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  logic [31:0] pend_q[$];
  logic [31:0] stale_q[$];
  logic [31:0] tmp_q[$];
  logic [31:0] model_pc, base, e_ins, a;
  logic [15:0] h0;
  int          n_ins;

  initial begin
    Rst = 1'b1; fetch_gnt = 1'b0; rsp_valid = 1'b0; rsp_addr = '0; rsp_data = '0;
    redirect = 1'b0; redirect_addr = '0; stall = 1'b0;

    // Reset values and basic 32-bit then two 16-bit instructions.
    nxt(); nxt(); smp();
    chk_reset_vals("rst");
    Rst = 1'b0;
    nxt();
    grant_n(2);
    smp();
    check_eq("t1_faddr", fetch_addr, 32'h8);
    send_rsp(32'h0, 32'h0041_0113);
    nxt();
    send_rsp(32'h4, 32'h4505_0505);
    smp(); chk_ins("t1_a", 32'h0041_0113, 32'h0, 1'b0);
    nxt(); rsp_valid = 1'b0;
    smp(); chk_ins("t1_b", 32'h0000_0505, 32'h4, 1'b1);
    nxt(); smp(); chk_ins("t1_c", 32'h0000_4505, 32'h6, 1'b1);
    nxt(); smp(); check_eq("t1_empty", {31'b0, ins_valid}, 32'd0);

    // 32-bit instruction straddling a word boundary.
    do_redirect(32'h10);
    grant_n(2);
    send_rsp(32'h10, 32'h0113_0505);
    nxt(); rsp_valid = 1'b0;
    smp(); chk_ins("t2_a", 32'h0000_0505, 32'h10, 1'b1);
    nxt(); smp();
    check_eq("t2_wait_v", {31'b0, ins_valid}, 32'd0);
    check_eq("t2_wait_ins", ins, 32'd0);
    nxt(); smp();
    check_eq("t2_wait2_v", {31'b0, ins_valid}, 32'd0);
    send_rsp(32'h14, 32'hABCD_0041);
    nxt(); rsp_valid = 1'b0;
    smp(); chk_ins("t2_b", 32'h0041_0113, 32'h12, 1'b0);
    nxt();

    // Redirect with requests in flight; stale responses must be ignored.
    do_redirect(32'h8);
    grant_n(2);
    redirect = 1'b1; redirect_addr = 32'h102;
    smp(); check_eq("t3_req_in_redir", {31'b0, fetch_req}, 32'd0);
    nxt(); redirect = 1'b0;
    smp(); check_eq("t3_faddr", fetch_addr, 32'h100);
    send_rsp(32'h8, 32'h1111_2222);
    nxt(); send_rsp(32'hC, 32'h3333_4444);
    smp(); check_eq("t3_stale0", {31'b0, ins_valid}, 32'd0);
    nxt(); rsp_valid = 1'b0;
    smp(); check_eq("t3_stale1", {31'b0, ins_valid}, 32'd0);
    grant_n(1);
    send_rsp(32'h100, 32'h8082_0001);
    nxt(); rsp_valid = 1'b0;
    smp(); chk_ins("t3_hi", 32'h0000_8082, 32'h102, 1'b1);
    nxt();

    // Redirect and matching response in the same cycle.
    grant_n(1);
    send_rsp(32'h104, 32'h0000_4501);
    redirect = 1'b1; redirect_addr = 32'h104;
    smp(); check_eq("t5_redir_v", {31'b0, ins_valid}, 32'd0);
    nxt(); redirect = 1'b0; rsp_valid = 1'b0;
    smp(); check_eq("t5_dropped", {31'b0, ins_valid}, 32'd0);
    grant_n(1);
    send_rsp(32'h104, 32'h0000_4501);
    nxt(); rsp_valid = 1'b0;
    smp(); chk_ins("t5_recover", 32'h0000_4501, 32'h104, 1'b1);
    nxt();

    // Stall with a full queue, then back-to-back consumption.
    stall = 1'b1;
    do_redirect(32'h200);
    grant_n(3);
    smp(); check_eq("t4_throttle", {31'b0, fetch_req}, 32'd0);
    send_rsp(32'h200, 32'h0201_0101); nxt();
    send_rsp(32'h204, 32'h0401_0301); nxt();
    send_rsp(32'h208, 32'h0601_0501); nxt();
    rsp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      smp();
      check_eq("t4_full_req", {31'b0, fetch_req}, 32'd0);
      chk_ins("t4_hold", 32'h0000_0101, 32'h200, 1'b1);
      nxt();
    end
    stall = 1'b0;
    for (int k = 0; k < 6; k++) begin
      smp();
      chk_ins("t4_drain", 32'h0000_0101 + 32'h100 * k, 32'h200 + 2 * k, 1'b1);
      nxt();
    end

    // Asynchronous reset mid-stream.
    do_redirect(32'h300);
    grant_n(2);
    send_rsp(32'h300, 32'h0001_4501);
    nxt(); rsp_valid = 1'b0; stall = 1'b1;
    smp(); chk_ins("t6_pre", 32'h0000_4501, 32'h300, 1'b1);
    #1 Rst = 1'b1;
    #1 chk_reset_vals("t6_async");
    nxt(); Rst = 1'b0; stall = 1'b0;
    send_rsp(32'h304, 32'h0001_0001);
    nxt(); rsp_valid = 1'b0;
    smp(); check_eq("t6_stale", {31'b0, ins_valid}, 32'd0);
    grant_n(1);
    send_rsp(32'h0, 32'h1234_4509);
    nxt(); rsp_valid = 1'b0;
    smp(); chk_ins("t6_restart", 32'h0000_4509, 32'h0, 1'b1);

    // Randomized run against the program-image model.
    Rst = 1'b1;
    nxt();
    Rst = 1'b0;
    model_pc = 32'h0;
    n_ins = 0;
    pend_q.delete();
    stale_q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      nxt();
      rsp_valid = 1'b0;
      if (stale_q.size() > 0) begin
        if ($urandom_range(0, 99) < 60) send_rsp(stale_q.pop_front(), $urandom());
      end else if (pend_q.size() > 0 && $urandom_range(0, 99) < 70) begin
        a = pend_q.pop_front();
        send_rsp(a, mem_word(a));
      end else if ($urandom_range(0, 99) < 5) begin
        send_rsp(32'hF000_0000 | ($urandom() & 32'h00FF_FFFC), $urandom());
      end
      fetch_gnt = ($urandom_range(0, 99) < 70);
      stall     = ($urandom_range(0, 99) < 25);
      redirect  = ($urandom_range(0, 99) < 3);
      if (redirect) begin
        if ($urandom_range(0, 3) == 0) redirect_addr = 32'hFFFF_FFE0 + $urandom_range(0, 31);
        else redirect_addr = $urandom_range(0, 1023);
      end
      smp();
      if (redirect) begin
        check_eq("rnd_redir_blank", {31'b0, ins_valid}, 32'd0);
      end else if (ins_valid) begin
        h0 = mem_hw(model_pc);
        e_ins = (h0[1:0] != 2'b11) ? {16'h0, h0} : {mem_hw(model_pc + 32'd2), h0};
        check_eq("rnd_ins", ins, e_ins);
        check_eq("rnd_pc", pres_addr, model_pc);
        check_eq("rnd_comp", {31'b0, comp_sig}, {31'b0, (h0[1:0] != 2'b11)});
        if (!stall) begin
          model_pc = model_pc + ((h0[1:0] != 2'b11) ? 32'd2 : 32'd4);
          n_ins++;
        end
      end else begin
        check_eq("rnd_ins_zero", ins, 32'd0);
      end
      if (fetch_req && fetch_gnt) pend_q.push_back(fetch_addr);
      if (redirect) begin
        // In-flight words become stale; keep only those that cannot alias
        // the restart region, so each one is guaranteed to be discarded.
        base = redirect_addr & ~32'd3;
        tmp_q = {stale_q, pend_q};
        stale_q.delete();
        pend_q.delete();
        foreach (tmp_q[i]) if ((tmp_q[i] - base) >= 32'd32) stale_q.push_back(tmp_q[i]);
        model_pc = redirect_addr & ~32'd1;
      end
    end
    redirect = 1'b0;
    rsp_valid = 1'b0;
    check_eq("rnd_progress", {31'b0, n_ins > 200}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
